// File: rtl/dvi_tx_link_ctrl.sv
// DVI transmit link bring-up controller: PLL lock qualification,
// PHY reset sequencing, warm-up frame blanking and DE gating.
module dvi_tx_link_ctrl #(
  parameter int unsigned RST_CYCLES  = 16,
  parameter int unsigned LOCK_FILT   = 4,
  parameter int unsigned WARM_FRAMES = 2,
  parameter bit          VS_POL      = 1'b1
) (
  input  logic       pixel_clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       pll_locked,
  input  logic       de_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic       phy_reset,
  output logic       de_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       link_up,
  output logic [1:0] state,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RESET_HOLD = 2'd1,
    ST_SYNC_WAIT  = 2'd2,
    ST_ACTIVE     = 2'd3
  } state_e;

  localparam int unsigned RW =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned LW =
    (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
  localparam int unsigned FW =
    (WARM_FRAMES > 1) ? $clog2(WARM_FRAMES) : 1;

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FILT - 1);
  localparam logic [FW-1:0] WARM_LAST = FW'(WARM_FRAMES - 1);

  state_e        state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          lock_ok_q, lock_ok_d;
  logic          vs_prev_q, vs_prev_d;
  logic [7:0]    loss_q, loss_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;

  logic          vs_edge;
  logic          abort;

  // Lock counter parks at its last value once lock qualifies.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    lock_ok_d  = lock_ok_q;
    if (!pll_locked) begin
      lock_cnt_d = '0;
      lock_ok_d  = 1'b0;
    end else if (lock_cnt_q == LOCK_LAST) begin
      lock_ok_d  = 1'b1;
    end else begin
      lock_cnt_d = lock_cnt_q + LW'(1);
    end
  end

  assign vs_edge = (vsync_in == VS_POL) &&
                   (vs_prev_q != VS_POL);

  assign abort = (state_q != ST_IDLE) &&
                 (!enable || !lock_ok_q);

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    frame_cnt_d = frame_cnt_q;
    loss_d      = loss_q;
    if (abort) begin
      state_d     = ST_IDLE;
      rst_cnt_d   = '0;
      frame_cnt_d = '0;
      if (!lock_ok_q && (loss_q != 8'hFF)) begin
        loss_d = loss_q + 8'd1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          rst_cnt_d   = '0;
          frame_cnt_d = '0;
          if (enable && lock_ok_q) begin
            state_d = ST_RESET_HOLD;
          end
        end
        ST_RESET_HOLD: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d   = ST_SYNC_WAIT;
            rst_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RW'(1);
          end
        end
        ST_SYNC_WAIT: begin
          if (vs_edge) begin
            if (frame_cnt_q == WARM_LAST) begin
              state_d     = ST_ACTIVE;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + FW'(1);
            end
          end
        end
        ST_ACTIVE: begin
          state_d = ST_ACTIVE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // DE is dropped in the same edge that leaves ACTIVE.
  always_comb begin
    de_d      = de_in && (state_q == ST_ACTIVE) &&
                (state_d == ST_ACTIVE);
    hs_d      = hsync_in;
    vs_d      = vsync_in;
    vs_prev_d = vsync_in;
  end

  always_ff @(posedge pixel_clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      frame_cnt_q <= '0;
      lock_cnt_q  <= '0;
      lock_ok_q   <= 1'b0;
      vs_prev_q   <= ~VS_POL;
      loss_q      <= '0;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      lock_ok_q   <= lock_ok_d;
      vs_prev_q   <= vs_prev_d;
      loss_q      <= loss_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
    end
  end

  assign phy_reset     = (state_q == ST_IDLE) ||
                         (state_q == ST_RESET_HOLD);
  assign link_up       = (state_q == ST_ACTIVE);
  assign state         = state_q;
  assign de_out        = de_q;
  assign hsync_out     = hs_q;
  assign vsync_out     = vs_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_dvi_tx_link_ctrl.sv
// Directed vector bench for dvi_tx_link_ctrl, run on an active-high
// and an active-low vsync instance fed with complementary vsync.
module tb_dvi_tx_link_ctrl;

  logic clk;
  logic rst_n, en, pll, de, hs, vs;
  logic vs_n;

  logic       phy_a, deo_a, hso_a, vso_a, lk_a;
  logic [1:0] st_a;
  logic [7:0] loss_a;
  logic       phy_b, deo_b, hso_b, vso_b, lk_b;
  logic [1:0] st_b;
  logic [7:0] loss_b;

  int checks = 0;
  int errors = 0;

  assign vs_n = ~vs;

  dvi_tx_link_ctrl #(.VS_POL(1'b1)) u_dut_a (
    .pixel_clock(clk), .reset_n(rst_n), .enable(en),
    .pll_locked(pll), .de_in(de), .hsync_in(hs),
    .vsync_in(vs), .phy_reset(phy_a), .de_out(deo_a),
    .hsync_out(hso_a), .vsync_out(vso_a), .link_up(lk_a),
    .state(st_a), .lock_loss_cnt(loss_a)
  );

  dvi_tx_link_ctrl #(.VS_POL(1'b0)) u_dut_b (
    .pixel_clock(clk), .reset_n(rst_n), .enable(en),
    .pll_locked(pll), .de_in(de), .hsync_in(hs),
    .vsync_in(vs_n), .phy_reset(phy_b), .de_out(deo_b),
    .hsync_out(hso_b), .vsync_out(vso_b), .link_up(lk_b),
    .state(st_b), .lock_loss_cnt(loss_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       rst_n, en, pll, de, hs, vs;
    int       n;
    bit [1:0] st;
    bit       phy, deo, hso, vso, lk;
    bit [7:0] loss;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit r, e, p, d, h, v, input int n,
                     input bit [1:0] st, input bit phy, deo,
                     hso, vso, lk, input bit [7:0] loss);
    vec_t t;
    t.rst_n = r; t.en = e; t.pll = p;
    t.de = d; t.hs = h; t.vs = v; t.n = n;
    t.st = st; t.phy = phy; t.deo = deo;
    t.hso = hso; t.vso = vso; t.lk = lk; t.loss = loss;
    tv.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_row(input int i, input vec_t t);
    bit vb;
    vb = t.rst_n ? ~t.vso : 1'b0;
    chk($sformatf("row%0d state_a", i), 32'(st_a), 32'(t.st));
    chk($sformatf("row%0d phy_a", i), 32'(phy_a), 32'(t.phy));
    chk($sformatf("row%0d de_a", i), 32'(deo_a), 32'(t.deo));
    chk($sformatf("row%0d hs_a", i), 32'(hso_a), 32'(t.hso));
    chk($sformatf("row%0d vs_a", i), 32'(vso_a), 32'(t.vso));
    chk($sformatf("row%0d link_a", i), 32'(lk_a), 32'(t.lk));
    chk($sformatf("row%0d loss_a", i), 32'(loss_a), 32'(t.loss));
    chk($sformatf("row%0d state_b", i), 32'(st_b), 32'(t.st));
    chk($sformatf("row%0d phy_b", i), 32'(phy_b), 32'(t.phy));
    chk($sformatf("row%0d de_b", i), 32'(deo_b), 32'(t.deo));
    chk($sformatf("row%0d hs_b", i), 32'(hso_b), 32'(t.hso));
    chk($sformatf("row%0d vs_b", i), 32'(vso_b), 32'(vb));
    chk($sformatf("row%0d link_b", i), 32'(lk_b), 32'(t.lk));
    chk($sformatf("row%0d loss_b", i), 32'(loss_b), 32'(t.loss));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; pll = 1'b0;
    de = 1'b0; hs = 1'b0; vs = 1'b0;

    // rst en pll de hs vs n | st phy de hs vs lk loss
    add(0,0,0,0,0,0, 3, 0,1,0,0,0,0,0);
    // pll glitching low every third cycle
    for (int k = 0; k < 3; k++) begin
      add(1,1,1,0,1,0, 2, 0,1,0,1,0,0,0);
      add(1,1,0,0,0,0, 1, 0,1,0,0,0,0,0);
    end
    // bring-up
    add(1,1,1,0,0,0, 4, 0,1,0,0,0,0,0);
    add(1,1,1,0,0,0, 1, 1,1,0,0,0,0,0);
    add(1,1,1,0,0,0,15, 1,1,0,0,0,0,0);
    add(1,1,1,0,0,0, 1, 2,0,0,0,0,0,0);
    add(1,1,1,0,1,1, 1, 2,0,0,1,1,0,0);
    add(1,1,1,1,0,1, 3, 2,0,0,0,1,0,0);
    add(1,1,1,1,0,0, 2, 2,0,0,0,0,0,0);
    add(1,1,1,1,0,1, 1, 3,0,0,0,1,1,0);
    add(1,1,1,1,0,1, 1, 3,0,1,0,1,1,0);
    add(1,1,1,0,1,0, 1, 3,0,0,1,0,1,0);
    add(1,1,1,1,0,0, 4, 3,0,1,0,0,1,0);
    // lock loss mid-line, then relock
    add(1,1,0,1,0,0, 1, 3,0,1,0,0,1,0);
    add(1,1,0,1,0,0, 1, 0,1,0,0,0,0,1);
    add(1,1,1,0,0,0, 4, 0,1,0,0,0,0,1);
    add(1,1,1,0,0,0, 1, 1,1,0,0,0,0,1);
    add(1,1,1,0,0,0,15, 1,1,0,0,0,0,1);
    add(1,1,1,0,0,0, 1, 2,0,0,0,0,0,1);
    // disable after one edge, re-enable needs two fresh edges
    add(1,1,1,0,0,1, 1, 2,0,0,0,1,0,1);
    add(1,1,1,0,0,0, 1, 2,0,0,0,0,0,1);
    add(1,0,1,0,0,0, 1, 0,1,0,0,0,0,1);
    add(1,1,1,0,0,0, 1, 1,1,0,0,0,0,1);
    add(1,1,1,0,0,0,15, 1,1,0,0,0,0,1);
    add(1,1,1,0,0,0, 1, 2,0,0,0,0,0,1);
    add(1,1,1,0,0,1, 1, 2,0,0,0,1,0,1);
    add(1,1,1,0,0,0, 2, 2,0,0,0,0,0,1);
    add(1,1,1,0,0,1, 1, 3,0,0,0,1,1,1);
    // reset pulse while ACTIVE, restart with inputs held
    add(1,1,1,1,0,1, 1, 3,0,1,0,1,1,1);
    add(0,1,1,1,1,1, 1, 0,1,0,0,0,0,0);
    add(1,1,1,1,1,1, 4, 0,1,0,1,1,0,0);
    add(1,1,1,1,1,1, 1, 1,1,0,1,1,0,0);
    add(1,1,1,1,1,1,15, 1,1,0,1,1,0,0);
    add(1,1,1,1,1,1, 1, 2,0,0,1,1,0,0);
    add(1,1,1,1,1,1, 3, 2,0,0,1,1,0,0);

    for (int i = 0; i < tv.size(); i++) begin
      rst_n = tv[i].rst_n; en = tv[i].en; pll = tv[i].pll;
      de = tv[i].de; hs = tv[i].hs; vs = tv[i].vs;
      repeat (tv[i].n) @(posedge clk);
      #1;
      chk_row(i, tv[i]);
    end

    // repeated lock-loss exits saturate the counter
    en = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      int exp_loss;
      pll = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      pll = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (i == 1 || i == 200 || i == 255 ||
          i == 256 || i == 300) begin
        exp_loss = (i > 255) ? 255 : i;
        chk($sformatf("sat%0d loss_a", i), 32'(loss_a),
            32'(exp_loss));
        chk($sformatf("sat%0d loss_b", i), 32'(loss_b),
            32'(exp_loss));
        chk($sformatf("sat%0d state_a", i), 32'(st_a), 32'd0);
        chk($sformatf("sat%0d phy_a", i), 32'(phy_a), 32'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvi_tx_link_ctrl.md
Name: dvi_tx_link_ctrl

Overview:
Bring-up and supervision controller for the DVI transmit path. It sits between the video timing source and the TMDS encoders/PHY lanes. It holds the PHY serialisers in reset until the PLL is stably locked, releases them, and forces blanking (control tokens only) for a configurable number of warm-up frames. Video DE passes through only once the link is frame-aligned, and the block drops back to a safe state on PLL lock loss or disable.

Parameters:
RST_CYCLES, 16, pixel_clock cycles phy_reset is held high after lock qualifies (min 1)
LOCK_FILT, 4, consecutive high samples of pll_locked required before lock is considered valid (min 1)
WARM_FRAMES, 2, vsync leading edges counted in SYNC_WAIT before video is enabled (min 1)
VS_POL, 1, active level of vsync_in (1 = active-high, 0 = active-low)

Ports:
pixel_clock  in  1  single clock for all logic
reset_n  in  1  synchronous, active-low reset
enable  in  1  link enable from config; level sensitive
pll_locked  in  1  serial-clock PLL lock, already synchronous to pixel_clock
de_in  in  1  video data enable from timing generator
hsync_in  in  1  hsync from timing generator
vsync_in  in  1  vsync from timing generator
phy_reset  out  1  active-high reset to the TMDS PHY lanes
de_out  out  1  gated DE to the encoders
hsync_out  out  1  registered hsync to the encoders
vsync_out  out  1  registered vsync to the encoders
link_up  out  1  high only in ACTIVE
state  out  2  IDLE=0, RESET_HOLD=1, SYNC_WAIT=2, ACTIVE=3
lock_loss_cnt  out  8  saturating count of lock-loss exits

Behaviour:
- One clock, pixel_clock. Reset is synchronous and active-low: reset_n sampled low on a pixel_clock edge forces reset regardless of other inputs.
- In reset: state=IDLE, phy_reset=1, de_out/hsync_out/vsync_out=0, link_up=0, lock_loss_cnt=0. All internal counters and the lock filter are cleared, and the vsync history register = ~VS_POL, i.e. inactive.
- Lock filter: lock_ok rises after LOCK_FILT consecutive cycles of pll_locked=1. Any single pll_locked=0 sample clears lock_ok and its counter on the next edge.
- IDLE:
  - phy_reset=1.
  - Go to RESET_HOLD when enable && lock_ok.
- RESET_HOLD:
  - phy_reset=1; the counter runs RST_CYCLES cycles.
  - On the last count, go to SYNC_WAIT. phy_reset is 0 from the first SYNC_WAIT cycle, so it is high for exactly RST_CYCLES cycles in this state.
- SYNC_WAIT:
  - phy_reset=0 and de_out forced 0; hsync/vsync pass through.
  - A vsync leading edge is vsync_in==VS_POL && previous vsync_in!=VS_POL.
  - Count leading edges. On the WARM_FRAMES-th edge, go to ACTIVE on the next clock. A leading edge present in the same cycle as state entry is counted.
- ACTIVE:
  - de_out=de_in registered; link_up=1.
- Abort from RESET_HOLD/SYNC_WAIT/ACTIVE:
  - On !enable or !lock_ok, go to IDLE on the next edge. phy_reset=1 and de_out=0 from the first IDLE cycle, and the frame and reset counters are cleared.
  - If lock_ok=0 caused the exit (including simultaneous with !enable), lock_loss_cnt increments, saturating at 255. An exit caused by enable alone does not increment it.
  - Abort has priority over every forward transition in the same cycle.
- Outputs are registered:
  - hsync_out/vsync_out = the inputs delayed 1 cycle in all non-reset states, including IDLE.
  - de_out = de_in delayed 1 cycle, AND-ed with being in ACTIVE in the cycle it was sampled.
  - Latency from input to output is 1 cycle.
- The block never generates partial lines itself. DE gating starts at a vsync edge, which falls in blanking for compliant timing.
- Re-entry: from IDLE, the full sequence (reset hold + WARM_FRAMES edges) repeats.

Test Plan:
1. Reset, then enable=1 and pll_locked=1 held, vsync toggling -> lock_ok after 4 cycles. RESET_HOLD lasts exactly 16 cycles with phy_reset=1. SYNC_WAIT follows with de_out=0. ACTIVE and link_up=1 occur 1 cycle after the 2nd vsync leading edge, and de_out then tracks de_in with 1-cycle latency.
2. Glitch pll_locked low for 1 cycle in every 3 -> lock_ok never asserts, state stays IDLE, phy_reset=1, lock_loss_cnt=0.
3. Drop pll_locked in ACTIVE mid-line with de_in=1 -> next cycle state=IDLE, phy_reset=1, de_out=0, lock_loss_cnt=1. Lock restored -> full sequence repeats.
4. Drop enable in SYNC_WAIT after 1 vsync edge -> IDLE, lock_loss_cnt unchanged. Re-enable -> 2 fresh edges are required before ACTIVE.
5. With VS_POL=0 and active-low vsync, leading edges are the 1->0 transitions. Run 300 lock-loss events -> lock_loss_cnt saturates at 255.
6. Assert reset_n=0 for 1 cycle while ACTIVE -> next cycle all outputs at reset values and lock_loss_cnt=0. Reset released with inputs unchanged -> sequence restarts from IDLE.
